result_stream_tx: RTL and testbench

AXI-Stream master transmitter that drains matrix-multiply results from the accelerator datapath back to the host side. It accepts one 32-bit result per cycle on a write strobe, the same `w_fifo_en`/`data_out` pair the matmul engine drives. Results are buffered in an internal FIFO and emitted as an AXI-Stream master, with `sm_tlast` on every BURST_LEN-th beat, a 4x4 result tile by default. It is the output end of the stream path whose input end is the matmul AXI-Stream slave.

---
 rtl/result_stream_tx.sv | 124 ++++++++++++
 tb/tb_result_stream_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_stream_tx.sv
// rtl/result_stream_tx.sv - FIFO-buffered AXI-Stream master for matmul results (RESULT_TX_TLAST_EN enables framing)
module result_stream_tx #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_fifo_en,
    input  logic [DATA_W-1:0] data_in,
    output logic              sm_tvalid,
    output logic [DATA_W-1:0] sm_tdata,
    output logic              sm_tlast,
    input  logic              sm_tready,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              overflow,
    output logic              tx_done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {ST_EMPTY, ST_VALID} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [AW:0]       count;
    logic              wr_en;
    logic              pop;

    // Full/empty come from the registered count only; the output register is not counted.
    assign fifo_full  = (count == (AW+1)'(DEPTH));
    assign fifo_empty = (count == '0);
    assign wr_en      = w_fifo_en && !fifo_full;
    assign sm_tvalid  = (state == ST_VALID);

    // Storage array; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= data_in;
    end

    // Pointers and occupancy; a simultaneous write and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky drop flag: a write attempted against a full FIFO is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       overflow <= 1'b0;
        else if (w_fifo_en && fifo_full)  overflow <= 1'b1;
    end

    // Output register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    // Refill the output register whenever it is free or being accepted; tready never feeds tvalid.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_VALID;
                end
            end
            ST_VALID: begin
                if (sm_tready) begin
                    if (!fifo_empty) pop       = 1'b1;
                    else             state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Output data register, loaded from the FIFO head on each pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   sm_tdata <= '0;
        else if (pop) sm_tdata <= mem[rd_ptr];
    end

`ifdef RESULT_TX_TLAST_EN
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [BW-1:0] beat_cnt;
    logic          handshake;

    assign handshake = sm_tvalid && sm_tready;
    assign sm_tlast  = sm_tvalid && (beat_cnt == BW'(BURST_LEN - 1));

    // Beat position within the packet, advanced per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         beat_cnt <= '0;
        else if (handshake) beat_cnt <= sm_tlast ? '0 : beat_cnt + 1'b1;
    end

    // Packet-complete pulse, one cycle after the tlast beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_done <= 1'b0;
        else        tx_done <= handshake && sm_tlast;
    end
`else
    assign sm_tlast = 1'b0;
    assign tx_done  = 1'b0;
`endif

endmodule

// File: tb/tb_result_stream_tx.sv
// tb/tb_result_stream_tx.sv - self-checking bench for result_stream_tx against a queue model
module tb_result_stream_tx;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 16;
    localparam int BURST_LEN = 16;
`ifdef RESULT_TX_TLAST_EN
    localparam bit TLAST_EN = 1'b1;
`else
    localparam bit TLAST_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              w_fifo_en;
    logic [DATA_W-1:0] data_in;
    logic              sm_tvalid;
    logic [DATA_W-1:0] sm_tdata;
    logic              sm_tlast;
    logic              sm_tready;
    logic              fifo_full;
    logic              fifo_empty;
    logic              overflow;
    logic              tx_done;

    int n_cmp = 0;
    int n_err = 0;

    result_stream_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .w_fifo_en  (w_fifo_en),
        .data_in    (data_in),
        .sm_tvalid  (sm_tvalid),
        .sm_tdata   (sm_tdata),
        .sm_tlast   (sm_tlast),
        .sm_tready  (sm_tready),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .overflow   (overflow),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic do_reset;
        rst_n     = 1'b0;
        w_fifo_en = 1'b0;
        data_in   = '0;
        sm_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        w_fifo_en = 1'b0;
        data_in   = '0;
        sm_tready = 1'b0;
        @(negedge clk);
        n_cmp++; if (sm_tvalid !== 1'b0)  begin n_err++; $display("FAIL reset_tvalid got=%b exp=0", sm_tvalid); end
        n_cmp++; if (sm_tlast !== 1'b0)   begin n_err++; $display("FAIL reset_tlast got=%b exp=0", sm_tlast); end
        n_cmp++; if (fifo_full !== 1'b0)  begin n_err++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
        n_cmp++; if (overflow !== 1'b0)   begin n_err++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        n_cmp++; if (tx_done !== 1'b0)    begin n_err++; $display("FAIL reset_tx_done got=%b exp=0", tx_done); end
        n_cmp++; if (sm_tdata !== '0)     begin n_err++; $display("FAIL reset_tdata got=%h exp=0", sm_tdata); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_streaming;
        logic exp_v;
        do_reset;
        for (int c = 0; c < 21; c++) begin
            w_fifo_en = (c < 16);
            data_in   = DATA_W'(c + 1);
            sm_tready = 1'b1;
            @(negedge clk);
            exp_v = (c >= 2 && c <= 17);
            n_cmp++; if (sm_tvalid !== exp_v) begin n_err++; $display("FAIL stream_tvalid c=%0d got=%b exp=%b", c, sm_tvalid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (sm_tdata !== DATA_W'(c - 1)) begin n_err++; $display("FAIL stream_tdata c=%0d got=%0d exp=%0d", c, sm_tdata, c - 1); end
            end
            n_cmp++; if (sm_tlast !== (TLAST_EN && c == 17)) begin n_err++; $display("FAIL stream_tlast c=%0d got=%b", c, sm_tlast); end
            n_cmp++; if (tx_done !== (TLAST_EN && c == 18)) begin n_err++; $display("FAIL stream_tx_done c=%0d got=%b", c, tx_done); end
            @(posedge clk); #1;
        end
        w_fifo_en = 1'b0;
    endtask

    task automatic test_backpressure;
        logic              exp_v;
        logic [DATA_W-1:0] exp_d;
        do_reset;
        for (int c = 0; c < 10; c++) begin
            w_fifo_en = (c < 2);
            data_in   = (c == 0) ? DATA_W'(32'hA5) : DATA_W'(32'hB6);
            sm_tready = (c >= 7);
            @(negedge clk);
            exp_v = (c >= 2 && c <= 8);
            exp_d = (c == 8) ? DATA_W'(32'hB6) : DATA_W'(32'hA5);
            n_cmp++; if (sm_tvalid !== exp_v) begin n_err++; $display("FAIL bp_tvalid c=%0d got=%b exp=%b", c, sm_tvalid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (sm_tdata !== exp_d) begin n_err++; $display("FAIL bp_tdata c=%0d got=%h exp=%h", c, sm_tdata, exp_d); end
            end
            n_cmp++; if (sm_tlast !== 1'b0) begin n_err++; $display("FAIL bp_tlast c=%0d got=%b exp=0", c, sm_tlast); end
            @(posedge clk); #1;
        end
        sm_tready = 1'b0;
    endtask

    task automatic test_overflow;
        int idx;
        do_reset;
        sm_tready = 1'b0;
        for (int c = 0; c < 18; c++) begin
            w_fifo_en = 1'b1;
            data_in   = DATA_W'(c);
            @(posedge clk); #1;
        end
        w_fifo_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL ovf_full c=%0d got=%b exp=1", c, fifo_full); end
            n_cmp++; if (overflow !== 1'b1)  begin n_err++; $display("FAIL ovf_flag c=%0d got=%b exp=1", c, overflow); end
            n_cmp++; if (sm_tvalid !== 1'b1 || sm_tdata !== '0) begin n_err++; $display("FAIL ovf_head c=%0d got=%b/%0d exp=1/0", c, sm_tvalid, sm_tdata); end
            @(posedge clk); #1;
        end
        sm_tready = 1'b1;
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky c=%0d got=%b exp=1", c, overflow); end
            if (sm_tvalid) begin
                n_cmp++; if (sm_tdata !== DATA_W'(idx)) begin n_err++; $display("FAIL ovf_tdata beat=%0d got=%0d exp=%0d", idx, sm_tdata, idx); end
                n_cmp++; if (sm_tlast !== (TLAST_EN && idx == 15)) begin n_err++; $display("FAIL ovf_tlast beat=%0d got=%b", idx, sm_tlast); end
                idx++;
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (idx != 17) begin n_err++; $display("FAIL ovf_beats got=%0d exp=17", idx); end
        sm_tready = 1'b0;
    endtask

    task automatic test_mid_reset;
        int  beats;
        int  idx;
        logic exp_done;
        do_reset;
        beats = 0;
        for (int c = 0; c < 40 && beats < 7; c++) begin
            w_fifo_en = (c < 16);
            data_in   = DATA_W'(c + 1);
            sm_tready = 1'b1;
            @(negedge clk);
            if (sm_tvalid) begin
                n_cmp++; if (sm_tdata !== DATA_W'(beats + 1)) begin n_err++; $display("FAIL mid_pre_tdata beat=%0d got=%0d exp=%0d", beats, sm_tdata, beats + 1); end
                beats++;
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (beats != 7) begin n_err++; $display("FAIL mid_pre_beats got=%0d exp=7", beats); end
        rst_n     = 1'b0;
        w_fifo_en = 1'b0;
        #1;
        n_cmp++; if (sm_tvalid !== 1'b0)  begin n_err++; $display("FAIL mid_rst_tvalid got=%b exp=0", sm_tvalid); end
        n_cmp++; if (sm_tlast !== 1'b0)   begin n_err++; $display("FAIL mid_rst_tlast got=%b exp=0", sm_tlast); end
        n_cmp++; if (tx_done !== 1'b0)    begin n_err++; $display("FAIL mid_rst_tx_done got=%b exp=0", tx_done); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL mid_rst_empty got=%b exp=1", fifo_empty); end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        idx      = 0;
        exp_done = 1'b0;
        for (int c = 0; c < 26; c++) begin
            w_fifo_en = (c < 16);
            data_in   = DATA_W'(c + 101);
            @(negedge clk);
            n_cmp++; if (tx_done !== exp_done) begin n_err++; $display("FAIL mid_tx_done c=%0d got=%b exp=%b", c, tx_done, exp_done); end
            exp_done = 1'b0;
            if (sm_tvalid) begin
                n_cmp++; if (sm_tdata !== DATA_W'(idx + 101)) begin n_err++; $display("FAIL mid_tdata beat=%0d got=%0d exp=%0d", idx, sm_tdata, idx + 101); end
                n_cmp++; if (sm_tlast !== (TLAST_EN && idx == 15)) begin n_err++; $display("FAIL mid_tlast beat=%0d got=%b", idx, sm_tlast); end
                exp_done = TLAST_EN && idx == 15;
                idx++;
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (idx != 16) begin n_err++; $display("FAIL mid_beats got=%0d exp=16", idx); end
        w_fifo_en = 1'b0;
        sm_tready = 1'b0;
    endtask

    task automatic test_random;
        logic [DATA_W-1:0] q[$];
        logic [DATA_W-1:0] exp_d;
        logic              exp_last;
        logic              exp_done;
        logic              prev_stall;
        logic              wr;
        int                beat;
        do_reset;
        beat       = 0;
        exp_done   = 1'b0;
        prev_stall = 1'b0;
        for (int c = 0; c < 460; c++) begin
            if (c < 400) begin
                wr        = ($urandom_range(0, 2) != 0) && (q.size() < DEPTH);
                sm_tready = 1'($urandom_range(0, 1));
            end else begin
                wr        = 1'b0;
                sm_tready = 1'b1;
            end
            w_fifo_en = wr;
            data_in   = DATA_W'($urandom);
            if (wr) q.push_back(data_in);
            @(negedge clk);
            n_cmp++; if (tx_done !== exp_done) begin n_err++; $display("FAIL rnd_tx_done c=%0d got=%b exp=%b", c, tx_done, exp_done); end
            n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rnd_overflow c=%0d got=%b exp=0", c, overflow); end
            if (prev_stall) begin
                n_cmp++; if (sm_tvalid !== 1'b1) begin n_err++; $display("FAIL rnd_tvalid_drop c=%0d got=%b exp=1", c, sm_tvalid); end
            end
            exp_done = 1'b0;
            if (sm_tvalid && sm_tready) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL rnd_extra_beat c=%0d got=%h exp=none", c, sm_tdata);
                end else begin
                    exp_d    = q.pop_front();
                    exp_last = TLAST_EN && (beat % BURST_LEN == BURST_LEN - 1);
                    n_cmp++; if (sm_tdata !== exp_d) begin n_err++; $display("FAIL rnd_tdata beat=%0d got=%h exp=%h", beat, sm_tdata, exp_d); end
                    n_cmp++; if (sm_tlast !== exp_last) begin n_err++; $display("FAIL rnd_tlast beat=%0d got=%b exp=%b", beat, sm_tlast, exp_last); end
                    exp_done = exp_last;
                    beat++;
                end
            end
            prev_stall = sm_tvalid && !sm_tready;
            @(posedge clk); #1;
        end
        n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL rnd_drain left=%0d exp=0", q.size()); end
        n_cmp++; if (sm_tvalid !== 1'b0 || fifo_empty !== 1'b1) begin n_err++; $display("FAIL rnd_idle got=%b/%b exp=0/1", sm_tvalid, fifo_empty); end
        sm_tready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        w_fifo_en = 1'b0;
        data_in   = '0;
        sm_tready = 1'b0;
        test_reset;
        test_streaming;
        test_backpressure;
        test_overflow;
        test_mid_reset;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
